cdb_arbiter: RTL

//   Shares the single Common Data Bus between the execution units (ALU, branch unit, load/store buffer, ...).

---
 rtl/cdb_arbiter_if.sv | 37 +++
 rtl/cdb_arbiter.sv | 112 +++++++++++
 2 files changed

// File: rtl/cdb_arbiter_if.sv
// rtl/cdb_arbiter_if.sv - execution-unit result requests and common data bus broadcast signals
interface cdb_arbiter_if #(
  parameter int NUM_REQ  = 4,
  parameter int ROB_ID_W = 4,
  parameter int DATA_W   = 32,
  parameter int ADDR_W   = 32
);
  logic [NUM_REQ-1:0]          req_valid;
  logic [NUM_REQ-1:0]          req_ready;
  logic [NUM_REQ*ROB_ID_W-1:0] req_rob_id;
  logic [NUM_REQ*DATA_W-1:0]   req_value;
  logic [NUM_REQ*ADDR_W-1:0]   req_addr;
  logic [NUM_REQ-1:0]          req_outcome;

  logic                        cdb_valid;
  logic [ROB_ID_W-1:0]         cdb_rob_id;
  logic [DATA_W-1:0]           cdb_value;
  logic [ADDR_W-1:0]           cdb_addr;
  logic                        cdb_branch_outcome;

  logic [31:0]                 cnt_grants;
  logic [31:0]                 cnt_conflict;

  modport master (
    output req_valid, req_rob_id, req_value, req_addr, req_outcome,
    input  req_ready,
    input  cdb_valid, cdb_rob_id, cdb_value, cdb_addr, cdb_branch_outcome,
    input  cnt_grants, cnt_conflict
  );

  modport slave (
    input  req_valid, req_rob_id, req_value, req_addr, req_outcome,
    output req_ready,
    output cdb_valid, cdb_rob_id, cdb_value, cdb_addr, cdb_branch_outcome,
    output cnt_grants, cnt_conflict
  );
endinterface

// File: rtl/cdb_arbiter.sv
// rtl/cdb_arbiter.sv - round-robin arbiter driving the registered common data bus
module cdb_arbiter #(
  parameter int NUM_REQ  = 4,
  parameter int ROB_ID_W = 4,
  parameter int DATA_W   = 32,
  parameter int ADDR_W   = 32
) (
  input  logic         clk,
  input  logic         rst,
  input  logic         flush,
  cdb_arbiter_if.slave bus
);
  localparam int PTR_W = (NUM_REQ > 1) ? $clog2(NUM_REQ) : 1;

  logic [PTR_W-1:0]    rr_ptr;
  logic [PTR_W-1:0]    gnt_idx;
  logic [PTR_W-1:0]    ptr_next;
  logic                gnt_found;
  logic [NUM_REQ-1:0]  hi_mask;
  logic [NUM_REQ-1:0]  hi_req;
  logic                multi_req;

  logic [ROB_ID_W-1:0] sel_rob_id;
  logic [DATA_W-1:0]   sel_value;
  logic [ADDR_W-1:0]   sel_addr;
  logic                sel_outcome;

  logic                cdb_valid_q;
  logic [ROB_ID_W-1:0] cdb_rob_id_q;
  logic [DATA_W-1:0]   cdb_value_q;
  logic [ADDR_W-1:0]   cdb_addr_q;
  logic                cdb_outcome_q;
  logic [31:0]         cnt_grants_q;
  logic [31:0]         cnt_conflict_q;

  // Requests at or above rr_ptr win; if none, fall back to the lowest valid index (wrap).
  always_comb begin
    hi_mask   = {NUM_REQ{1'b1}} << rr_ptr;
    hi_req    = bus.req_valid & hi_mask;
    gnt_found = 1'b0;
    gnt_idx   = '0;
    for (int i = NUM_REQ - 1; i >= 0; i--) begin
      if (bus.req_valid[i]) begin
        gnt_found = 1'b1;
        gnt_idx   = PTR_W'(i);
      end
    end
    for (int i = NUM_REQ - 1; i >= 0; i--) begin
      if (hi_req[i]) begin
        gnt_idx = PTR_W'(i);
      end
    end
    if (rst || flush) begin
      gnt_found = 1'b0;
    end
  end

  assign ptr_next  = (gnt_idx == PTR_W'(NUM_REQ - 1)) ? '0 : gnt_idx + 1'b1;
  assign multi_req = ($countones(bus.req_valid) >= 2);

  always_comb begin
    sel_rob_id  = '0;
    sel_value   = '0;
    sel_addr    = '0;
    sel_outcome = 1'b0;
    for (int i = 0; i < NUM_REQ; i++) begin
      if (gnt_idx == PTR_W'(i)) begin
        sel_rob_id  = bus.req_rob_id[i*ROB_ID_W +: ROB_ID_W];
        sel_value   = bus.req_value[i*DATA_W +: DATA_W];
        sel_addr    = bus.req_addr[i*ADDR_W +: ADDR_W];
        sel_outcome = bus.req_outcome[i];
      end
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      rr_ptr         <= '0;
      cdb_valid_q    <= 1'b0;
      cdb_rob_id_q   <= '0;
      cdb_value_q    <= '0;
      cdb_addr_q     <= '0;
      cdb_outcome_q  <= 1'b0;
      cnt_grants_q   <= '0;
      cnt_conflict_q <= '0;
    end else begin
      cdb_valid_q <= gnt_found;
      if (gnt_found) begin
        cdb_rob_id_q  <= sel_rob_id;
        cdb_value_q   <= sel_value;
        cdb_addr_q    <= sel_addr;
        cdb_outcome_q <= sel_outcome;
        rr_ptr        <= ptr_next;
        cnt_grants_q  <= cnt_grants_q + 32'd1;
        if (multi_req) begin
          cnt_conflict_q <= cnt_conflict_q + 32'd1;
        end
      end
    end
  end

  assign bus.req_ready = gnt_found ? (NUM_REQ'(1) << gnt_idx) : '0;

  // A broadcast registered just before a flush must not reach the ROB or wake-up logic.
  assign bus.cdb_valid          = cdb_valid_q & ~flush;
  assign bus.cdb_rob_id         = cdb_rob_id_q;
  assign bus.cdb_value          = cdb_value_q;
  assign bus.cdb_addr           = cdb_addr_q;
  assign bus.cdb_branch_outcome = cdb_outcome_q;
  assign bus.cnt_grants         = cnt_grants_q;
  assign bus.cnt_conflict       = cnt_conflict_q;
endmodule
